// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Holds the FSM state encoding, byte/word widths and the default WAIT-state timeout.
package uart_tx_sched_pkg;

    localparam int BYTE_W          = 8;
    localparam int WORD_W          = 16;
    localparam int TIMEOUT_DEFAULT = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_HI,
        S_WAIT_HI,
        S_SEND_LO,
        S_WAIT_LO
    } sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Bundle of the two requester handshakes, the UART transmitter handshake and status flags.
// The slave modport is the scheduler's view; master is the surrounding system's view.
interface uart_tx_scheduler_if;
    import uart_tx_sched_pkg::*;

    logic              req0_valid;
    logic [WORD_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [WORD_W-1:0] req1_data;
    logic              req1_ready;
    logic              tx_busy;
    logic              tx_start;
    logic [BYTE_W-1:0] tx_data;
    logic              sched_busy;
    logic              grant_id;
    logic              timeout_err;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_busy,
        input  req0_ready, req1_ready, tx_start, tx_data, sched_busy, grant_id, timeout_err
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_busy,
        output req0_ready, req1_ready, tx_start, tx_data, sched_busy, grant_id, timeout_err
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester grant logic: round-robin by default, fixed priority to requester 0
// when TX_SCHED_FIXED_PRIO_EN is defined (no pointer register in that build).
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_enable,
    input  logic [1:0] i_req,
    output logic [1:0] o_grant
);

`ifdef TX_SCHED_FIXED_PRIO_EN
    logic w_unused;

    assign w_unused   = clk ^ reset;
    assign o_grant[0] = i_enable & i_req[0];
    assign o_grant[1] = i_enable & i_req[1] & ~i_req[0];
`else
    logic r_lastGrant;
    logic w_pick1;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign w_pick1    = i_req[1] & (~i_req[0] | ~r_lastGrant);
    assign o_grant[1] = i_enable & w_pick1;
    assign o_grant[0] = i_enable & i_req[0] & ~w_pick1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lastGrant <= 1'b1;
        end else if (|o_grant) begin
            r_lastGrant <= o_grant[1];
        end
    end
`endif

endmodule

// File: rtl/uart_tx_scheduler.sv
// Accepts 16-bit words from two requesters and sends each as two UART bytes, high byte first.
// Arbitration mode is selected by TX_SCHED_FIXED_PRIO_EN inside rr_arb2.
module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input logic                clk,
    input logic                reset,
    uart_tx_scheduler_if.slave bus
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    sched_state_t      r_state;
    logic [WORD_W-1:0] r_buffer;
    logic [CNT_W-1:0]  r_count;
    logic              r_grantId;

    logic [1:0]        w_grant;
    logic              w_arbEn;
    logic              w_inSend;
    logic              w_inWait;
    logic              w_sendNow;
    logic              w_timeout;
    logic [BYTE_W-1:0] w_byte;

    // Grants are only offered from IDLE and are masked while reset is held.
    assign w_arbEn = (r_state == S_IDLE) & ~reset;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .i_enable (w_arbEn),
        .i_req    ({bus.req1_valid, bus.req0_valid}),
        .o_grant  (w_grant)
    );

    assign w_inSend  = (r_state == S_SEND_HI) | (r_state == S_SEND_LO);
    assign w_inWait  = (r_state == S_WAIT_HI) | (r_state == S_WAIT_LO);
    assign w_sendNow = w_inSend & ~bus.tx_busy;
    assign w_timeout = w_inWait & bus.tx_busy & (r_count == CNT_LAST);
    assign w_byte    = (r_state == S_SEND_HI) ? r_buffer[WORD_W-1:BYTE_W] : r_buffer[BYTE_W-1:0];

    assign bus.req0_ready  = w_grant[0];
    assign bus.req1_ready  = w_grant[1];
    assign bus.tx_start    = w_sendNow;
    assign bus.tx_data     = w_sendNow ? w_byte : '0;
    assign bus.sched_busy  = (r_state != S_IDLE);
    assign bus.grant_id    = r_grantId;
    assign bus.timeout_err = w_timeout;

    // The WAIT counter is cleared on the SEND->WAIT transition so each WAIT starts from zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_buffer  <= '0;
            r_count   <= '0;
            r_grantId <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_grant) begin
                        r_buffer  <= w_grant[1] ? bus.req1_data : bus.req0_data;
                        r_grantId <= w_grant[1];
                        r_state   <= S_SEND_HI;
                    end
                end
                S_SEND_HI: begin
                    if (!bus.tx_busy) begin
                        r_count <= '0;
                        r_state <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (!bus.tx_busy) begin
                        r_state <= S_SEND_LO;
                    end else if (r_count == CNT_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                S_SEND_LO: begin
                    if (!bus.tx_busy) begin
                        r_count <= '0;
                        r_state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!bus.tx_busy || (r_count == CNT_LAST)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (TIMEOUT=8); expected tie-break
// results follow TX_SCHED_FIXED_PRIO_EN when it is defined.
module tb_uart_tx_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic modelBusy = 1'b0;
    logic forceBusy = 1'b0;
    logic sawStart = 1'b0;
    int   busyCnt = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] startQ[$];
    int         startCyc[$];
    int         grantQ[$];
    int         grantCyc[$];

    uart_tx_scheduler_if bus ();

    uart_tx_scheduler #(.TIMEOUT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.tx_busy = modelBusy | forceBusy;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART model: busy rises the cycle after tx_start and stays high for three cycles.
    initial begin
        forever begin
            @(negedge clk);
            sawStart = bus.tx_start;
            @(posedge clk);
            #1;
            if (reset) busyCnt = 0;
            else if (sawStart) busyCnt = 3;
            else if (busyCnt > 0) busyCnt = busyCnt - 1;
            modelBusy = (busyCnt > 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_start) begin
                startQ.push_back(bus.tx_data);
                startCyc.push_back(cyc);
            end
            if (bus.req0_ready || bus.req1_ready) begin
                grantQ.push_back(bus.req1_ready ? 1 : 0);
                grantCyc.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic v0, input logic [15:0] d0,
                                 input logic v1, input logic [15:0] d1);
        bus.req0_valid = v0;
        bus.req0_data  = d0;
        bus.req1_valid = v1;
        bus.req1_data  = d1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.sched_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_idle"}, bus.sched_busy, 0);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_tx_start"}, bus.tx_start, 0);
        checkOutput({tag, "_tx_data"}, bus.tx_data, 0);
        checkOutput({tag, "_ready0"}, bus.req0_ready, 0);
        checkOutput({tag, "_ready1"}, bus.req1_ready, 0);
        checkOutput({tag, "_sched_busy"}, bus.sched_busy, 0);
        checkOutput({tag, "_grant_id"}, bus.grant_id, 0);
        checkOutput({tag, "_timeout_err"}, bus.timeout_err, 0);
    endtask

    initial begin
        int         sb;
        int         gb;
        int         n;
        int         expId;
        logic       found;
        logic [7:0] expB[6];
        logic [15:0] words[3];

        applyStimulus(0, 16'h0000, 0, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("rst");
        nextCycle();
        reset = 1'b0;

        // Single send of 16'hA55A from requester 0.
        nextCycle();
        sb = startQ.size();
        applyStimulus(1, 16'hA55A, 0, 16'h0000);
        @(negedge clk);
        checkOutput("t1_ready0", bus.req0_ready, 1);
        checkOutput("t1_ready1", bus.req1_ready, 0);
        checkOutput("t1_nostart", bus.tx_start, 0);
        nextCycle();
        applyStimulus(0, 16'h0000, 0, 16'h0000);
        @(negedge clk);
        checkOutput("t1_start_hi", bus.tx_start, 1);
        checkOutput("t1_data_hi", bus.tx_data, 8'hA5);
        checkOutput("t1_busy", bus.sched_busy, 1);
        checkOutput("t1_ready_low", bus.req0_ready, 0);
        waitIdle("t1");
        checkOutput("t1_nbytes", startQ.size() - sb, 2);
        checkOutput("t1_byte_lo", startQ[sb+1], 8'h5A);
        checkOutput("t1_lo_delay", startCyc[sb+1] - startCyc[sb], 5);
        checkOutput("t1_idle_data", bus.tx_data, 0);

        // Tie between both requesters after a fresh reset.
        nextCycle();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        gb = grantQ.size();
        sb = startQ.size();
        applyStimulus(1, 16'h1111, 1, 16'h2222);
        @(negedge clk);
        checkOutput("t2_first_ready0", bus.req0_ready, 1);
        checkOutput("t2_first_ready1", bus.req1_ready, 0);
        n = 0;
        while (grantQ.size() < gb + 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        nextCycle();
        applyStimulus(0, 16'h0000, 0, 16'h0000);
        waitIdle("t2");
        checkOutput("t2_ngrants", grantQ.size() - gb, 4);
        for (int i = 0; i < 4; i++) begin
`ifdef TX_SCHED_FIXED_PRIO_EN
            expId = 0;
`else
            expId = i % 2;
`endif
            checkOutput("t2_grant", grantQ[gb+i], expId);
            checkOutput("t2_byte_hi", startQ[sb+2*i], (expId == 1) ? 8'h22 : 8'h11);
            checkOutput("t2_byte_lo", startQ[sb+2*i+1], (expId == 1) ? 8'h22 : 8'h11);
        end

        // Transmitter busy on entry to SEND_HI for five cycles.
        nextCycle();
        forceBusy = 1'b1;
        sb = startQ.size();
        applyStimulus(1, 16'hBEEF, 0, 16'h0000);
        @(negedge clk);
        checkOutput("t3_ready0", bus.req0_ready, 1);
        nextCycle();
        applyStimulus(0, 16'h0000, 0, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t3_stall", bus.tx_start, 0);
            checkOutput("t3_stall_data", bus.tx_data, 0);
            nextCycle();
        end
        forceBusy = 1'b0;
        @(negedge clk);
        checkOutput("t3_start", bus.tx_start, 1);
        checkOutput("t3_data_hi", bus.tx_data, 8'hBE);
        waitIdle("t3");
        checkOutput("t3_nbytes", startQ.size() - sb, 2);
        checkOutput("t3_byte_lo", startQ[sb+1], 8'hEF);

        // Timeout: transmitter stuck busy after the high byte.
        nextCycle();
        sb = startQ.size();
        applyStimulus(0, 16'h0000, 1, 16'hC33C);
        @(negedge clk);
        checkOutput("t4_ready1", bus.req1_ready, 1);
        checkOutput("t4_ready0", bus.req0_ready, 0);
        nextCycle();
        applyStimulus(0, 16'h0000, 0, 16'h0000);
        @(negedge clk);
        checkOutput("t4_start_hi", bus.tx_start, 1);
        checkOutput("t4_data_hi", bus.tx_data, 8'hC3);
        checkOutput("t4_grant_id", bus.grant_id, 1);
        nextCycle();
        forceBusy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkOutput("t4_no_err", bus.timeout_err, 0);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("t4_err", bus.timeout_err, 1);
        checkOutput("t4_err_busy", bus.sched_busy, 1);
        nextCycle();
        @(negedge clk);
        checkOutput("t4_err_pulse", bus.timeout_err, 0);
        checkOutput("t4_idle", bus.sched_busy, 0);
        nextCycle();
        forceBusy = 1'b0;
        repeat (10) nextCycle();
        checkOutput("t4_nbytes", startQ.size() - sb, 1);

        // Reset in WAIT_LO with requester 1 pending.
        sb = startQ.size();
        applyStimulus(1, 16'h1234, 0, 16'h0000);
        @(negedge clk);
        checkOutput("t5_ready0", bus.req0_ready, 1);
        nextCycle();
        applyStimulus(0, 16'h0000, 1, 16'h5678);
        found = 1'b0;
        n = 0;
        while (!found && n < 60) begin
            @(negedge clk);
            if (bus.tx_start && bus.tx_data == 8'h34) found = 1'b1;
            n++;
        end
        checkOutput("t5_lo_seen", found, 1);
        nextCycle();
        reset = 1'b1;
        @(negedge clk);
        checkResetOutputs("t5_rst");
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("t5_ready1", bus.req1_ready, 1);
        checkOutput("t5_ready0", bus.req0_ready, 0);
        nextCycle();
        applyStimulus(0, 16'h0000, 0, 16'h0000);
        waitIdle("t5");
        checkOutput("t5_nbytes", startQ.size() - sb, 4);
        checkOutput("t5_after_rst_hi", startQ[sb+2], 8'h56);
        checkOutput("t5_after_rst_lo", startQ[sb+3], 8'h78);

        // Back-to-back words from requester 0 with valid held high.
        words[0] = 16'hA1B2;
        words[1] = 16'hC3D4;
        words[2] = 16'hE5F6;
        expB[0] = 8'hA1; expB[1] = 8'hB2; expB[2] = 8'hC3;
        expB[3] = 8'hD4; expB[4] = 8'hE5; expB[5] = 8'hF6;
        sb = startQ.size();
        gb = grantQ.size();
        nextCycle();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, words[k], 0, 16'h0000);
            n = 0;
            @(negedge clk);
            while (!bus.req0_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            checkOutput("t6_grant", bus.req0_ready, 1);
            nextCycle();
        end
        applyStimulus(0, 16'h0000, 0, 16'h0000);
        waitIdle("t6");
        checkOutput("t6_nbytes", startQ.size() - sb, 6);
        for (int i = 0; i < 6; i++) begin
            checkOutput("t6_byte", startQ[sb+i], expB[i]);
        end
        checkOutput("t6_latency", startCyc[sb] - grantCyc[gb], 1);
        checkOutput("t6_gap1", grantCyc[gb+1] - grantCyc[gb], 11);
        checkOutput("t6_gap2", grantCyc[gb+2] - grantCyc[gb+1], 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
